axi_r_channel_slave_sram: RTL and testbench
===========================================

# axi_r_channel_slave_sram

AXI3-style read-channel slave that accepts read addresses from the core's AXI read master and returns data from a single-port synchronous SRAM (1-cycle read latency). Supports single and burst reads (FIXED/INCR/WRAP, up to 16 beats), one outstanding transaction, and RID echo. It is the stage directly downstream of the read master on the AR channel and directly upstream of it on the R channel.

## Interface
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, AXI byte-address width.
- ID_WIDTH, 6, transaction ID width.
- MEM_ADDR_WIDTH, 12, SRAM word-address width (depth 2^MEM_ADDR_WIDTH words).
- ACLK  in  1  clock.
- ARESETn  in  1  reset, synchronous, active-low; clock ACLK.
- ARADDR  in  ADDR_WIDTH  read byte address.
- ARLEN  in  4  beats minus one.
- ARSIZE  in  3  beat size; only 3'b010 is legal.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARID  in  ID_WIDTH  transaction ID.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready (registered).
- RDATA  out  DATA_WIDTH  read data (registered).
- RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- RLAST  out  1  last beat.
- RID  out  ID_WIDTH  echoes the latched ARID.
- RVALID  out  1  data valid.
- RREADY  in  1  master ready.
- mem_en  out  1  SRAM read enable.
- mem_addr  out  MEM_ADDR_WIDTH  SRAM word address.
- mem_rdata  in  DATA_WIDTH  SRAM data, valid the cycle after mem_en.

## Operation
- FSM states: IDLE, READ, WAIT, RESP. Reset state: IDLE.
- IDLE: ARREADY=1. On ARVALID&&ARREADY, latch word address ARADDR[MEM_ADDR_WIDTH+1:2], ARLEN, ARBURST, ARID, and the error class, clear the beat counter, set ARREADY<=0, and go to READ.
- READ: drive mem_en=1 with mem_addr equal to the current word address, then go to WAIT. For DECERR transactions mem_en stays 0.
- WAIT: on the clock edge, RDATA<=mem_rdata (0 for DECERR), RVALID<=1, RLAST<=(beat==latched ARLEN), and RID/RRESP load. Go to RESP.
- RESP: hold RDATA, RRESP, RLAST, RID, and RVALID stable until RREADY.
  - On RVALID&&RREADY with RLAST=0: RVALID<=0, beat increments, address advances, go to READ.
  - On RVALID&&RREADY with RLAST=1: RVALID<=0, RLAST<=0, ARREADY<=1, go to IDLE.
- Address advance (word address, MEM_ADDR_WIDTH bits, wraps modulo memory depth):
  - FIXED: unchanged.
  - INCR and reserved: +1.
  - WRAP with ARLEN in {1,3,7,15}: +1 within the aligned block of ARLEN+1 words (low log2(ARLEN+1) bits wrap; upper bits are held).
  - WRAP with any other ARLEN: treated as INCR with SLVERR.
- RRESP priority:
  - DECERR if ARADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] != 0. The whole burst returns RDATA=0, the full ARLEN+1 beats are still returned, and SRAM is never enabled.
  - Otherwise SLVERR if ARSIZE!=3'b010, ARBURST==2'b11, or WRAP with an illegal ARLEN. The SRAM is still read.
  - Otherwise OKAY.
  - Applies identically to every beat of a burst.
- ARADDR[1:0] is ignored.
- Only one transaction is outstanding. ARVALID is never accepted before the last beat completes.

## Timing
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0, mem_en=0, mem_addr=0.
- ARREADY rises in the first cycle after ARESETn deasserts.
- AR handshake in cycle T: mem_en=1 in T+1, RVALID=1 from T+3.
- Beat spacing with RREADY held high is 3 cycles: handshake in cycle H, next RVALID from H+3.
- Last-beat handshake in cycle L: ARREADY=1 in L+1, and the next AR can be accepted in L+1.
- RVALID never depends combinationally on RREADY. Once RVALID is asserted, outputs are stable until the handshake.
- Reset asserted mid-burst: all outputs return to reset values on the next edge and the burst is abandoned (no RLAST). ARREADY=1 the cycle after release.
- mem_en is a single-cycle pulse per beat; mem_addr holds its last value when mem_en=0.

## Test plan
- Single read: SRAM word 0x010=0xDEADBEEF; AR ARADDR=0x40, ARLEN=0, ARBURST=01, ARID=5 -> one beat RDATA=0xDEADBEEF, RLAST=1, RID=5, RRESP=00, RVALID 3 cycles after the AR handshake.
- INCR burst with backpressure: ARADDR=0x100, ARLEN=3, RREADY toggled 1-of-3 cycles -> data from words 0x40..0x43 in order, RLAST only on the 4th beat, outputs stable while RREADY=0, ARREADY=0 until 1 cycle after the last beat.
- WRAP: ARADDR=0x08, ARLEN=3, ARBURST=10 -> mem_addr sequence 2,3,0,1, RRESP=00. Repeat with ARLEN=2 -> sequence 2,3,4 with RRESP=10 on all beats.
- FIXED and errors:
  - FIXED ARADDR=0x20, ARLEN=2 -> word 8 read three times.
  - ARSIZE=3'b001 -> SLVERR.
  - ARADDR=0x0001_0000, ARLEN=1 -> 2 beats of DECERR, RDATA=0, mem_en never asserted.
- Reset mid-burst: assert ARESETn=0 during beat 2 of an 8-beat INCR -> next edge RVALID=0, ARREADY=0, mem_en=0. After release, ARREADY=1 next cycle and a new single read returns correct data and ID.

Source files
------------

// File: rtl/axi_r_channel_slave_sram_if.sv
// AXI3 read-address and read-data channel bundle between the core's read master and an SRAM-backed slave.
// Master drives AR* and RREADY; slave drives ARREADY and R*.
interface axi_r_channel_slave_sram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 6
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic [ID_WIDTH-1:0]   ARID;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [ID_WIDTH-1:0]   RID;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RID, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RID, RVALID
  );
endinterface

// File: rtl/axi_r_channel_slave_sram.sv
// AXI3 read slave over a 1-cycle-latency SRAM: one outstanding burst, RVALID 3 cycles after AR,
// 3-cycle beat spacing; R outputs are held until RREADY and never depend on it combinationally.
module axi_r_channel_slave_sram #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 6,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  axi_r_channel_slave_sram_if.slave bus,
  output logic                      o_mem_en,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t                    r_state;
  logic                      r_arready;
  logic                      r_rvalid;
  logic                      r_rlast;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic [1:0]                r_rresp;
  logic [ID_WIDTH-1:0]       r_rid;
  logic                      r_mem_en;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;

  // Latched transaction context
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [3:0]                r_len;
  logic [3:0]                r_beat;
  logic                      r_fixed;
  logic                      r_wrap;
  logic [ID_WIDTH-1:0]       r_id;
  logic [1:0]                r_resp_cls;

  logic [MEM_ADDR_WIDTH-1:0] w_ar_word;
  logic                      w_ar_decerr;
  logic                      w_ar_wrap_len_ok;
  logic                      w_ar_slverr;
  logic                      w_ar_wrap;
  logic [1:0]                w_ar_resp;
  logic                      w_cur_decerr;
  logic [MEM_ADDR_WIDTH-1:0] w_addr_inc;
  logic [MEM_ADDR_WIDTH-1:0] w_wrap_mask;
  logic [MEM_ADDR_WIDTH-1:0] w_next_addr;
  logic                      w_unused_addr_lsb;

  assign w_ar_word         = bus.ARADDR[MEM_ADDR_WIDTH+1:2];
  assign w_ar_decerr       = |bus.ARADDR[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
  assign w_ar_wrap_len_ok  = (bus.ARLEN == 4'd1) || (bus.ARLEN == 4'd3) ||
                             (bus.ARLEN == 4'd7) || (bus.ARLEN == 4'd15);
  assign w_ar_wrap         = (bus.ARBURST == 2'b10) && w_ar_wrap_len_ok;
  assign w_ar_slverr       = (bus.ARSIZE != 3'b010) || (bus.ARBURST == 2'b11) ||
                             ((bus.ARBURST == 2'b10) && !w_ar_wrap_len_ok);
  assign w_unused_addr_lsb = ^bus.ARADDR[1:0];

  always_comb begin
    w_ar_resp = RESP_OKAY;
    if (w_ar_decerr) begin
      w_ar_resp = RESP_DECERR;
    end else if (w_ar_slverr) begin
      w_ar_resp = RESP_SLVERR;
    end
  end

  assign w_cur_decerr = (r_resp_cls == RESP_DECERR);

  // A legal WRAP length is 2^k-1, so ARLEN itself is the mask of the wrapping low bits.
  assign w_addr_inc  = r_addr + {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_wrap_mask = {{(MEM_ADDR_WIDTH-4){1'b0}}, r_len};

  always_comb begin
    w_next_addr = w_addr_inc;
    if (r_fixed) begin
      w_next_addr = r_addr;
    end else if (r_wrap) begin
      w_next_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state    <= S_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rid      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_fixed    <= 1'b0;
      r_wrap     <= 1'b0;
      r_id       <= '0;
      r_resp_cls <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          // First cycle out of reset only raises ARREADY; AR is taken from then on.
          if (!r_arready) begin
            r_arready <= 1'b1;
          end else if (bus.ARVALID) begin
            r_arready  <= 1'b0;
            r_addr     <= w_ar_word;
            r_len      <= bus.ARLEN;
            r_beat     <= '0;
            r_fixed    <= (bus.ARBURST == 2'b00);
            r_wrap     <= w_ar_wrap;
            r_id       <= bus.ARID;
            r_resp_cls <= w_ar_resp;
            r_mem_en   <= !w_ar_decerr;
            if (!w_ar_decerr) begin
              r_mem_addr <= w_ar_word;
            end
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          r_mem_en <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_rdata  <= w_cur_decerr ? '0 : i_mem_rdata;
          r_rvalid <= 1'b1;
          r_rlast  <= (r_beat == r_len);
          r_rid    <= r_id;
          r_rresp  <= r_resp_cls;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (r_rvalid && bus.RREADY) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_beat   <= r_beat + 4'd1;
              r_addr   <= w_next_addr;
              r_mem_en <= !w_cur_decerr;
              if (!w_cur_decerr) begin
                r_mem_addr <= w_next_addr;
              end
              r_state  <= S_READ;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ARREADY = r_arready;
  assign bus.RVALID  = r_rvalid;
  assign bus.RLAST   = r_rlast;
  assign bus.RDATA   = r_rdata;
  assign bus.RRESP   = r_rresp;
  assign bus.RID     = r_rid;
  assign o_mem_en    = r_mem_en;
  assign o_mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_axi_r_channel_slave_sram.sv
// Bench for axi_r_channel_slave_sram: SRAM model plus a burst-level reference model computed
// from address arithmetic; directed cases followed by randomized transactions.
module tb_axi_r_channel_slave_sram;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 6;
  localparam int MW = 12;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          mem_en;
  logic [MW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] mem [1<<MW];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_viol = 0;
  logic prev_en = 1'b0;
  logic [MW-1:0] mem_q[$];

  axi_r_channel_slave_sram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_r_channel_slave_sram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_ADDR_WIDTH(MW)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .bus(bus),
    .o_mem_en(mem_en),
    .o_mem_addr(mem_addr),
    .i_mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  always @(negedge ACLK) begin
    if (mem_en) mem_q.push_back(mem_addr);
    if (mem_en && prev_en) pulse_viol++;
    prev_en = mem_en;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ar(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [IW-1:0] id);
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARBURST = burst;
    bus.ARSIZE  = size;
    bus.ARID    = id;
    bus.ARVALID = 1'b1;
  endtask

  // Called and returns at a negedge. rmode: 0 RREADY high, 1 one-in-three, 2 random.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [IW-1:0] id, input int rmode);
    int n, beat, to, cyc_hs, last_hs;
    logic decerr, wrap_ok, seen;
    logic [1:0] resp;
    logic [MW-1:0] word;
    logic [MW-1:0] exp_q[$];
    logic [40:0] held;

    n       = int'(len) + 1;
    word    = addr[MW+1:2];
    decerr  = (addr[AW-1:MW+2] != '0);
    wrap_ok = (n == 2) || (n == 4) || (n == 8) || (n == 16);
    if (decerr) resp = 2'b11;
    else if (size != 3'b010 || burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) resp = 2'b10;
    else resp = 2'b00;
    for (int i = 0; i < n; i++) begin
      if (burst == 2'b00) exp_q.push_back(word);
      else if (burst == 2'b10 && wrap_ok)
        exp_q.push_back(MW'((int'(word) / n) * n + (int'(word) % n + i) % n));
      else exp_q.push_back(MW'(int'(word) + i));
    end

    mem_q.delete();
    to = 0;
    while (!bus.ARREADY && to < 20) begin
      @(negedge ACLK);
      to++;
    end
    check("ar_ready_idle", bus.ARREADY, 1);
    drive_ar(addr, len, burst, size, id);
    cyc_hs = cyc;
    @(negedge ACLK);
    bus.ARVALID = 1'b0;

    beat = 0; to = 0; seen = 1'b0; last_hs = cyc_hs; held = '0;
    while (beat < n && to < 400) begin
      if (rmode == 0) bus.RREADY = 1'b1;
      else if (rmode == 1) bus.RREADY = (cyc % 3 == 0);
      else bus.RREADY = 1'($urandom_range(0, 1));
      check("ar_ready_busy", bus.ARREADY, 0);
      if (bus.RVALID) begin
        if (!seen) begin
          seen = 1'b1;
          held = {bus.RDATA, bus.RRESP, bus.RID, bus.RLAST};
          check("r_latency", cyc - last_hs, 3);
          check("r_data", bus.RDATA, decerr ? 32'h0 : mem[exp_q[beat]]);
          check("r_resp", bus.RRESP, resp);
          check("r_id", bus.RID, id);
          check("r_last", bus.RLAST, (beat == n - 1));
        end else begin
          check("r_stable", {bus.RDATA, bus.RRESP, bus.RID, bus.RLAST}, held);
        end
        if (bus.RREADY) begin
          last_hs = cyc;
          beat++;
          seen = 1'b0;
        end
      end
      @(negedge ACLK);
      to++;
    end
    bus.RREADY = 1'b0;
    check("beats_done", beat, n);
    check("ar_ready_after_last", bus.ARREADY, 1);
    check("rvalid_after_last", bus.RVALID, 0);
    check("mem_beats", mem_q.size(), decerr ? 0 : n);
    for (int i = 0; i < mem_q.size() && i < n; i++) check("mem_addr_seq", mem_q[i], exp_q[i]);
  endtask

  initial begin
    int nhs, to;
    logic [31:0] raddr;

    for (int i = 0; i < (1 << MW); i++) mem[i] = $urandom;
    mem[12'h010] = 32'hDEADBEEF;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'b010; bus.ARBURST = 2'b01;
    bus.ARID = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    repeat (3) @(negedge ACLK);
    check("rst_arready", bus.ARREADY, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rlast", bus.RLAST, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_rresp", bus.RRESP, 0);
    check("rst_rid", bus.RID, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("arready_after_release", bus.ARREADY, 1);

    run_txn(32'h0000_0040, 4'd0, 2'b01, 3'b010, 6'd5, 0);
    check("single_deadbeef", mem[12'h010], 32'hDEADBEEF);
    run_txn(32'h0000_0100, 4'd3, 2'b01, 3'b010, 6'd17, 1);
    run_txn(32'h0000_0008, 4'd3, 2'b10, 3'b010, 6'd33, 0);
    run_txn(32'h0000_0008, 4'd2, 2'b10, 3'b010, 6'd34, 0);
    run_txn(32'h0000_0020, 4'd2, 2'b00, 3'b010, 6'd40, 1);
    run_txn(32'h0000_0300, 4'd1, 2'b01, 3'b001, 6'd41, 0);
    run_txn(32'h0001_0000, 4'd1, 2'b01, 3'b010, 6'd42, 0);
    run_txn(32'h0000_3FF8, 4'd5, 2'b01, 3'b010, 6'd43, 2);
    run_txn(32'h0000_0400, 4'd2, 2'b11, 3'b010, 6'd44, 0);

    // Reset in the middle of an 8-beat INCR, while beat 2 is presented
    drive_ar(32'h0000_0200, 4'd7, 2'b01, 3'b010, 6'd9);
    @(negedge ACLK);
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    nhs = 0; to = 0;
    while (!(bus.RVALID && nhs == 1) && to < 50) begin
      if (bus.RVALID) nhs++;
      @(negedge ACLK);
      to++;
    end
    check("midburst_beat2", {bus.RVALID, 8'(nhs)}, {1'b1, 8'd1});
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    check("midrst_rvalid", bus.RVALID, 0);
    check("midrst_arready", bus.ARREADY, 0);
    check("midrst_mem_en", mem_en, 0);
    check("midrst_rlast", bus.RLAST, 0);
    check("midrst_rdata", bus.RDATA, 0);
    @(negedge ACLK);
    bus.RREADY = 1'b0;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("midrst_arready_release", bus.ARREADY, 1);
    run_txn(32'h0000_0044, 4'd0, 2'b01, 3'b010, 6'd12, 0);

    for (int t = 0; t < 30; t++) begin
      raddr = ($urandom_range(0, 7) == 0) ? $urandom : (32'($urandom) & 32'h0000_3FFF);
      run_txn(raddr, 4'($urandom), 2'($urandom),
              ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b010,
              6'($urandom), 2);
    end

    check("mem_en_single_pulse", pulse_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed simulation still running expected finished");
    $fatal(1, "timeout");
  end
endmodule
